spi_transaction_sequencer: RTL and testbench

Fabric-side command sequencer sitting directly upstream of the bidirectional (half-duplex) SPI core, in the fabric_clk domain. It queues host SPI transactions (length, data, rw mask), validates them, and issues them one at a time to the SPI core over a valid/ready request channel. It waits for the read-back word with a timeout, masks it, and returns one response per command over a valid/ready response channel.

---
 rtl/spi_seq_pkg.sv | 16 +
 rtl/spi_cmd_fifo.sv | 51 +++++
 rtl/spi_transaction_sequencer.sv | 160 ++++++++++++++++
 tb/tb_spi_transaction_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_seq_pkg.sv
// Shared types and helpers for the SPI transaction sequencer.
package spi_seq_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2,
    RESPOND  = 2'd3
  } state_t;

  // A transaction must clock at least one bit and no more bits than the data word holds.
  function automatic logic valid_length(input int unsigned len, input int unsigned width);
    return (len != 0) && (len <= width);
  endfunction

endpackage

// File: rtl/spi_cmd_fifo.sv
// Single-clock command FIFO; the head entry is visible combinationally on rdata.
module spi_cmd_fifo #(
  parameter int unsigned WIDTH  = 72,
  parameter int unsigned ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              pop,
  output logic [WIDTH-1:0]  rdata,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (level == (ADDR_W+1)'(DEPTH));
  assign empty   = (level == '0);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/spi_transaction_sequencer.sv
// Queues host SPI commands and runs them one at a time against the SPI core,
// returning one masked, in-order response per command.
module spi_transaction_sequencer
  import spi_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH            = 32,
  parameter int unsigned TRANSACTION_LEN_WIDTH = 8,
  parameter int unsigned FIFO_ADDR_WIDTH       = 2,
  parameter int unsigned TIMEOUT_CYCLES        = 1024
) (
  input  logic                             fabric_clk,
  input  logic                             reset_n,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [TRANSACTION_LEN_WIDTH-1:0] cmd_length,
  input  logic [DATA_WIDTH-1:0]            cmd_data,
  input  logic [DATA_WIDTH-1:0]            cmd_rw_mask,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [DATA_WIDTH-1:0]            rsp_data,
  output logic                             rsp_error,
  output logic                             rsp_timeout,
  output logic                             spi_req_valid,
  input  logic                             spi_req_ready,
  output logic [TRANSACTION_LEN_WIDTH-1:0] spi_req_length,
  output logic [DATA_WIDTH-1:0]            spi_req_data,
  output logic [DATA_WIDTH-1:0]            spi_req_rw_mask,
  input  logic                             spi_rsp_valid,
  input  logic [DATA_WIDTH-1:0]            spi_rsp_data,
  output logic                             busy,
  output logic [FIFO_ADDR_WIDTH:0]         fifo_level,
  output logic                             protocol_err
);

  localparam int unsigned ENTRY_W = TRANSACTION_LEN_WIDTH + 2 * DATA_WIDTH;
  localparam int unsigned CNT_W   = $clog2(TIMEOUT_CYCLES);

  function automatic logic [DATA_WIDTH-1:0] len_mask(input logic [TRANSACTION_LEN_WIDTH-1:0] len);
    logic [DATA_WIDTH-1:0] m;
    for (int i = 0; i < DATA_WIDTH; i++) m[i] = (i < int'(len));
    return m;
  endfunction

  state_t                           state, state_d;
  logic [CNT_W-1:0]                 cnt, cnt_d;
  logic                             err_q, err_d;
  logic                             to_q, to_d;
  logic                             perr_q;
  logic                             pop;
  logic                             fifo_full;
  logic                             fifo_empty;
  logic [ENTRY_W-1:0]               head;
  logic [TRANSACTION_LEN_WIDTH-1:0] head_len;
  logic [DATA_WIDTH-1:0]            head_data;
  logic [DATA_WIDTH-1:0]            head_mask;
  logic [TRANSACTION_LEN_WIDTH-1:0] req_len_p0;
  logic [DATA_WIDTH-1:0]            req_data_p0;
  logic [DATA_WIDTH-1:0]            req_mask_p0;
  logic [DATA_WIDTH-1:0]            rsp_data_p1;

  spi_cmd_fifo #(
    .WIDTH  (ENTRY_W),
    .ADDR_W (FIFO_ADDR_WIDTH)
  ) u_fifo (
    .clk   (fabric_clk),
    .rst_n (reset_n),
    .push  (cmd_valid && cmd_ready),
    .wdata ({cmd_length, cmd_data, cmd_rw_mask}),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign {head_len, head_data, head_mask} = head;

  always_ff @(posedge fabric_clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      err_q  <= 1'b0;
      to_q   <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      err_q <= err_d;
      to_q  <= to_d;
      if (spi_rsp_valid && (state != WAIT_RSP)) perr_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    err_d   = err_q;
    to_d    = to_q;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          err_d   = !valid_length(32'(head_len), DATA_WIDTH);
          to_d    = 1'b0;
          state_d = err_d ? RESPOND : ISSUE;
        end
      end
      ISSUE: begin
        if (spi_req_ready) begin
          state_d = WAIT_RSP;
          cnt_d   = '0;
        end
      end
      WAIT_RSP: begin
        if (spi_rsp_valid) begin
          state_d = RESPOND;
        end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = RESPOND;
          to_d    = 1'b1;
        end else if (cnt != '1) begin
          cnt_d = cnt + 1'b1;
        end
      end
      RESPOND: begin
        if (rsp_ready) begin
          state_d = IDLE;
          err_d   = 1'b0;
          to_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // stage p0: command held for the SPI core; stage p1: masked read word
  always_ff @(posedge fabric_clk) begin
    if (pop) begin
      req_len_p0  <= head_len;
      req_data_p0 <= head_data;
      req_mask_p0 <= head_mask;
      rsp_data_p1 <= '0;
    end else if ((state == WAIT_RSP) && spi_rsp_valid) begin
      rsp_data_p1 <= spi_rsp_data & ~req_mask_p0 & len_mask(req_len_p0);
    end
  end

  assign cmd_ready       = !fifo_full;
  assign busy            = (state != IDLE) || !fifo_empty;
  assign protocol_err    = perr_q;
  assign spi_req_valid   = (state == ISSUE);
  assign spi_req_length  = spi_req_valid ? req_len_p0  : '0;
  assign spi_req_data    = spi_req_valid ? req_data_p0 : '0;
  assign spi_req_rw_mask = spi_req_valid ? req_mask_p0 : '0;
  assign rsp_valid       = (state == RESPOND);
  assign rsp_data        = (rsp_valid && !to_q) ? rsp_data_p1 : '0;
  assign rsp_error       = err_q;
  assign rsp_timeout     = to_q;

endmodule

// File: tb/tb_spi_transaction_sequencer.sv
// Directed bench for the SPI transaction sequencer with a 16-cycle timeout.
module tb_spi_transaction_sequencer;

  logic        fabric_clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_length;
  logic [31:0] cmd_data;
  logic [31:0] cmd_rw_mask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_error;
  logic        rsp_timeout;
  logic        spi_req_valid;
  logic        spi_req_ready;
  logic [7:0]  spi_req_length;
  logic [31:0] spi_req_data;
  logic [31:0] spi_req_rw_mask;
  logic        spi_rsp_valid;
  logic [31:0] spi_rsp_data;
  logic        busy;
  logic [2:0]  fifo_level;
  logic        protocol_err;

  int n_cmp = 0;
  int n_err = 0;
  logic req_seen;

  always #5 fabric_clk = ~fabric_clk;

  spi_transaction_sequencer #(
    .DATA_WIDTH            (32),
    .TRANSACTION_LEN_WIDTH (8),
    .FIFO_ADDR_WIDTH       (2),
    .TIMEOUT_CYCLES        (16)
  ) dut (
    .fabric_clk      (fabric_clk),
    .reset_n         (reset_n),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_length      (cmd_length),
    .cmd_data        (cmd_data),
    .cmd_rw_mask     (cmd_rw_mask),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_data        (rsp_data),
    .rsp_error       (rsp_error),
    .rsp_timeout     (rsp_timeout),
    .spi_req_valid   (spi_req_valid),
    .spi_req_ready   (spi_req_ready),
    .spi_req_length  (spi_req_length),
    .spi_req_data    (spi_req_data),
    .spi_req_rw_mask (spi_req_rw_mask),
    .spi_rsp_valid   (spi_rsp_valid),
    .spi_rsp_data    (spi_rsp_data),
    .busy            (busy),
    .fifo_level      (fifo_level),
    .protocol_err    (protocol_err)
  );

  always @(posedge fabric_clk) if (spi_req_valid) req_seen <= 1'b1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge fabric_clk);
      #1;
    end
  endtask

  task automatic push_cmd(input logic [7:0] len, input logic [31:0] data, input logic [31:0] mask);
    cmd_valid   = 1'b1;
    cmd_length  = len;
    cmd_data    = data;
    cmd_rw_mask = mask;
    step(1);
    cmd_valid   = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 40 && !spi_req_valid; i++) step(1);
    chk(tag, spi_req_valid, 1);
  endtask

  task automatic wait_rsp(input string tag);
    for (int i = 0; i < 40 && !rsp_valid; i++) step(1);
    chk(tag, rsp_valid, 1);
  endtask

  task automatic handshake_req();
    spi_req_ready = 1'b1;
    step(1);
    spi_req_ready = 1'b0;
  endtask

  task automatic pulse_rsp(input logic [31:0] word);
    spi_rsp_valid = 1'b1;
    spi_rsp_data  = word;
    step(1);
    spi_rsp_valid = 1'b0;
    spi_rsp_data  = '0;
  endtask

  task automatic ack_rsp();
    rsp_ready = 1'b1;
    step(1);
    rsp_ready = 1'b0;
  endtask

  initial begin
    reset_n       = 1'b0;
    cmd_valid     = 1'b0;
    cmd_length    = '0;
    cmd_data      = '0;
    cmd_rw_mask   = '0;
    rsp_ready     = 1'b0;
    spi_req_ready = 1'b0;
    spi_rsp_valid = 1'b0;
    spi_rsp_data  = '0;
    req_seen      = 1'b0;
    step(3);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_req_valid", spi_req_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_perr", protocol_err, 0);
    reset_n = 1'b1;
    step(2);

    // write-only transaction
    push_cmd(8'd16, 32'h0000A5C3, 32'h0000FFFF);
    chk("wr_level_after_push", fifo_level, 1);
    chk("wr_req_not_yet", spi_req_valid, 0);
    step(1);
    chk("wr_req_valid", spi_req_valid, 1);
    chk("wr_req_len", spi_req_length, 16);
    chk("wr_req_data", spi_req_data, 32'h0000A5C3);
    chk("wr_req_mask", spi_req_rw_mask, 32'h0000FFFF);
    chk("wr_level_after_pop", fifo_level, 0);
    handshake_req();
    chk("wr_req_dropped", spi_req_valid, 0);
    pulse_rsp(32'hFFFFFFFF);
    chk("wr_rsp_valid", rsp_valid, 1);
    chk("wr_rsp_data", rsp_data, 0);
    chk("wr_rsp_err", rsp_error, 0);
    chk("wr_rsp_to", rsp_timeout, 0);
    step(1);
    chk("wr_rsp_held", rsp_valid, 1);
    ack_rsp();
    chk("wr_rsp_gone", rsp_valid, 0);
    chk("wr_idle", busy, 0);

    // read transaction, masked to the low 24 bits with bits 16..23 written
    push_cmd(8'd24, 32'h00000000, 32'h00FF0000);
    wait_req("rd_req");
    handshake_req();
    pulse_rsp(32'hDEADBEEF);
    chk("rd_rsp_valid", rsp_valid, 1);
    chk("rd_rsp_data", rsp_data, 32'h0000BEEF);
    chk("rd_rsp_err", rsp_error, 0);
    ack_rsp();

    // invalid lengths never reach the SPI core
    req_seen = 1'b0;
    push_cmd(8'd0, 32'h12345678, 32'h0);
    push_cmd(8'd33, 32'h12345678, 32'h0);
    chk("len0_rsp_valid", rsp_valid, 1);
    chk("len0_err", rsp_error, 1);
    chk("len0_data", rsp_data, 0);
    chk("len0_to", rsp_timeout, 0);
    chk("len0_level", fifo_level, 1);
    ack_rsp();
    wait_rsp("len33_rsp");
    chk("len33_err", rsp_error, 1);
    chk("len33_data", rsp_data, 0);
    ack_rsp();
    step(1);
    chk("inv_no_req", req_seen, 0);

    // timeout expires 16 cycles after the request handshake
    push_cmd(8'd8, 32'h0, 32'h0);
    wait_req("to_req");
    handshake_req();
    step(15);
    chk("to_not_early", rsp_valid, 0);
    step(1);
    chk("to_rsp_valid", rsp_valid, 1);
    chk("to_flag", rsp_timeout, 1);
    chk("to_data", rsp_data, 0);
    chk("to_err", rsp_error, 0);
    ack_rsp();

    // a response on the expiry cycle wins over the timeout
    push_cmd(8'd8, 32'h0, 32'h0);
    wait_req("late_req");
    handshake_req();
    step(15);
    chk("late_not_early", rsp_valid, 0);
    pulse_rsp(32'h12345678);
    chk("late_rsp_valid", rsp_valid, 1);
    chk("late_to", rsp_timeout, 0);
    chk("late_data", rsp_data, 32'h00000078);
    ack_rsp();

    // fill the FIFO while the SPI core stalls
    for (int i = 0; i < 5; i++) push_cmd(8'd8, 32'(i), 32'h0);
    chk("full_level", fifo_level, 4);
    chk("full_cmd_ready", cmd_ready, 0);
    push_cmd(8'd8, 32'h55, 32'h0);
    chk("full_no_push", fifo_level, 4);
    for (int i = 0; i < 5; i++) begin
      wait_req("ord_req");
      chk("ord_req_data", spi_req_data, 32'(i));
      handshake_req();
      pulse_rsp(32'hA0 + 32'(i));
      chk("ord_rsp_valid", rsp_valid, 1);
      chk("ord_rsp_data", rsp_data, 32'hA0 + 32'(i));
      ack_rsp();
    end
    step(2);
    chk("drain_busy", busy, 0);
    chk("drain_rsp_valid", rsp_valid, 0);

    // stray response in IDLE is sticky
    pulse_rsp(32'hFFFFFFFF);
    chk("perr_set", protocol_err, 1);
    chk("perr_no_rsp", rsp_valid, 0);
    step(3);
    chk("perr_sticky", protocol_err, 1);

    // reset during WAIT_RSP with a command still queued
    push_cmd(8'd8, 32'h1, 32'h0);
    wait_req("rst_req");
    push_cmd(8'd8, 32'h2, 32'h0);
    handshake_req();
    chk("pre_rst_level", fifo_level, 1);
    chk("pre_rst_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    chk("mid_rst_level", fifo_level, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_perr", protocol_err, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_req_valid", spi_req_valid, 0);
    chk("mid_rst_rsp_data", rsp_data, 0);
    step(2);
    reset_n = 1'b1;
    step(4);
    chk("post_rst_rsp_valid", rsp_valid, 0);
    chk("post_rst_req_valid", spi_req_valid, 0);
    chk("post_rst_level", fifo_level, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
